dpram_axi_burst_writer: RTL

DPRAM_AXI_BURST_WRITER -- requirements
Module: dpram_axi_burst_writer

---
 rtl/dpram_axi_burst_writer_if.sv | 38 +++
 rtl/dpram_axi_burst_writer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dpram_axi_burst_writer_if.sv
// AXI4 write-only channel bundle (AW, W, B) between the DPRAM burst writer and its slave.
interface dpram_axi_burst_writer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/dpram_axi_burst_writer.sv
// Streams consecutive DPRAM words out as AXI4 INCR write bursts, one burst outstanding at a time.
// Optional macro AXI_WR_BRESP_CHECK_EN: latch non-OKAY write responses into a sticky wr_err.
module dpram_axi_burst_writer #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 256,
    parameter int C_M_AXI_BURST_LEN  = 8,
    parameter int C_NUM_CH           = 2,
    parameter int C_DPRAM_ADDR_WIDTH = 10
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          wr_req,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] wr_base_addr,
    input  logic [15:0]                   wr_burst_cnt,
    input  logic [C_DPRAM_ADDR_WIDTH-1:0] wr_dpram_start,
    output logic                          wr_busy,
    output logic                          wr_done,
    output logic                          wr_err,
    output logic [C_DPRAM_ADDR_WIDTH-1:0] dpram_addrb,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] dpram_dout,
    dpram_axi_burst_writer_if.master      m_axi
);
    localparam int BEAT_BYTES  = C_M_AXI_DATA_WIDTH / 8;
    localparam int BURST_BYTES = C_M_AXI_BURST_LEN * BEAT_BYTES;
    localparam int LANE_W      = C_M_AXI_DATA_WIDTH / C_NUM_CH;
    localparam int RD_CNT_W    = 25;
    localparam int FIFO_DEPTH  = 4;

    typedef enum logic [2:0] {ST_IDLE, ST_AW, ST_W, ST_B, ST_DONE} state_t;
    state_t state_reg, state_next;

    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_reg;
    logic [15:0]                   bursts_left_reg;
    logic [RD_CNT_W-1:0]           reads_left_reg;
    logic [C_DPRAM_ADDR_WIDTH-1:0] rd_addr_reg;
    logic [1:0]                    rd_pipe_reg;
    logic [7:0]                    beat_cnt_reg;
    logic [C_M_AXI_DATA_WIDTH-1:0] fifo_mem_reg [FIFO_DEPTH];
    logic [1:0]                    fifo_wr_ptr_reg;
    logic [1:0]                    fifo_rd_ptr_reg;
    logic [2:0]                    fifo_cnt_reg;

    logic [C_M_AXI_DATA_WIDTH-1:0] push_data;
    logic [3:0]                    pending;
    logic req_accept, rd_issue, fifo_push, fifo_pop, wvalid, last_beat, b_hs;

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_CH; gi++) begin : g_lane
            assign push_data[gi*LANE_W +: LANE_W] = dpram_dout[gi*LANE_W +: LANE_W];
        end
    endgenerate

    // Reads in the 2-cycle DPRAM pipe count against FIFO space so a push never overflows.
    always_comb begin
        req_accept = (state_reg == ST_IDLE) && wr_req;
        wvalid     = (state_reg == ST_W) && (fifo_cnt_reg != 3'd0);
        last_beat  = (beat_cnt_reg == 8'(C_M_AXI_BURST_LEN - 1));
        fifo_pop   = wvalid && m_axi.wready;
        fifo_push  = rd_pipe_reg[1];
        b_hs       = (state_reg == ST_B) && m_axi.bvalid;
        pending    = {1'b0, fifo_cnt_reg} + {3'b0, rd_pipe_reg[0]} + {3'b0, rd_pipe_reg[1]};
        rd_issue   = ((state_reg == ST_AW) || (state_reg == ST_W) || (state_reg == ST_B)) &&
                     (reads_left_reg != '0) && (pending < 4'd4);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (wr_req) state_next = (wr_burst_cnt == 16'd0) ? ST_DONE : ST_AW;
            ST_AW:   if (m_axi.awready) state_next = ST_W;
            ST_W:    if (fifo_pop && last_beat) state_next = ST_B;
            ST_B:    if (m_axi.bvalid) state_next = (bursts_left_reg == 16'd1) ? ST_DONE : ST_AW;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_reg       <= ST_IDLE;
            awaddr_reg      <= '0;
            bursts_left_reg <= '0;
            reads_left_reg  <= '0;
            rd_addr_reg     <= '0;
            rd_pipe_reg     <= '0;
            beat_cnt_reg    <= '0;
            fifo_wr_ptr_reg <= '0;
            fifo_rd_ptr_reg <= '0;
            fifo_cnt_reg    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_reg[i] <= '0;
        end else begin
            state_reg   <= state_next;
            rd_pipe_reg <= {rd_pipe_reg[0], rd_issue};
            if (req_accept) begin
                awaddr_reg      <= wr_base_addr;
                bursts_left_reg <= wr_burst_cnt;
                reads_left_reg  <= RD_CNT_W'(wr_burst_cnt) * RD_CNT_W'(C_M_AXI_BURST_LEN);
                rd_addr_reg     <= wr_dpram_start;
                beat_cnt_reg    <= '0;
            end
            if (b_hs) begin
                bursts_left_reg <= bursts_left_reg - 16'd1;
                if (bursts_left_reg != 16'd1)
                    awaddr_reg <= awaddr_reg + C_M_AXI_ADDR_WIDTH'(BURST_BYTES);
            end
            if (rd_issue) begin
                rd_addr_reg    <= rd_addr_reg + 1'b1;
                reads_left_reg <= reads_left_reg - 1'b1;
            end
            if (fifo_push) begin
                fifo_mem_reg[fifo_wr_ptr_reg] <= push_data;
                fifo_wr_ptr_reg <= fifo_wr_ptr_reg + 2'd1;
            end
            if (fifo_pop) begin
                fifo_rd_ptr_reg <= fifo_rd_ptr_reg + 2'd1;
                beat_cnt_reg    <= last_beat ? 8'd0 : beat_cnt_reg + 8'd1;
            end
            fifo_cnt_reg <= fifo_cnt_reg + {2'b0, fifo_push} - {2'b0, fifo_pop};
        end
    end

`ifdef AXI_WR_BRESP_CHECK_EN
    logic err_reg;
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET)
            err_reg <= 1'b0;
        else if (req_accept)
            err_reg <= 1'b0;
        else if (b_hs && (m_axi.bresp != 2'b00))
            err_reg <= 1'b1;
    end
    assign wr_err = err_reg;
`else
    logic unused_bresp;
    assign unused_bresp = ^m_axi.bresp;
    assign wr_err       = 1'b0;
`endif

    assign wr_busy       = (state_reg != ST_IDLE);
    assign wr_done       = (state_reg == ST_DONE);
    assign dpram_addrb   = rd_addr_reg;
    assign m_axi.awaddr  = awaddr_reg;
    assign m_axi.awlen   = 8'(C_M_AXI_BURST_LEN - 1);
    assign m_axi.awsize  = 3'($clog2(BEAT_BYTES));
    assign m_axi.awburst = 2'b01;
    assign m_axi.awvalid = (state_reg == ST_AW);
    assign m_axi.wdata   = fifo_mem_reg[fifo_rd_ptr_reg];
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = wvalid;
    assign m_axi.wlast   = wvalid && last_beat;
    assign m_axi.bready  = (state_reg == ST_B);
endmodule
